// File: rtl/ultrasound_pkg.sv
// Shared types and constants for the ultrasound echo receiver.
// The ECHO_GLITCH_FILTER_EN build macro is consumed by echo_qualifier.
package ultrasound_pkg;

    localparam int NUM_CH    = 4;
    localparam int TOF_W_DEF = 14;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LISTEN,
        REPORT
    } state_t;

endpackage

// File: rtl/echo_qualifier.sv
// Per-channel comparator qualifier: 2-flop synchronizer plus optional
// debounce filter, enabled by defining ECHO_GLITCH_FILTER_EN.
module echo_qualifier #(
    parameter int DEBOUNCE = 8
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic echo_in,
    output logic qual
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= echo_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef ECHO_GLITCH_FILTER_EN
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] run_cnt;

    // Saturates at DEBOUNCE so a held echo keeps qualifying.
    always_ff @(posedge clk_50M) begin
        if (rst || !sync_q2) begin
            run_cnt <= '0;
        end else if (run_cnt != CW'(DEBOUNCE)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign qual = (run_cnt == CW'(DEBOUNCE));
`else
    localparam int unused_debounce = DEBOUNCE;

    assign qual = sync_q2;
`endif

endmodule

// File: rtl/ultrasound_echo_receiver.sv
// 4-channel echo timestamping receiver with valid/ready result stream.
// Define ECHO_GLITCH_FILTER_EN to debounce the comparator inputs.
module ultrasound_echo_receiver
    import ultrasound_pkg::*;
#(
    parameter int TICK_DIV  = 50,
    parameter int BLANK_US  = 300,
    parameter int WINDOW_US = 9500,
    parameter int DEBOUNCE  = 8,
    parameter int TOF_W     = TOF_W_DEF
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             launch,
    input  logic [3:0]       echo_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_ch,
    output logic             res_hit,
    output logic [TOF_W-1:0] res_tof,
    output logic             busy,
    output logic             missed
);

    localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_CH);

    state_t state;
    state_t state_nxt;

    logic [CYC_W-1:0]  cyc_cnt;
    logic [TOF_W-1:0]  us_cnt;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] hit;
    logic [TOF_W-1:0]  tof [NUM_CH];
    logic [IDX_W-1:0]  rpt_idx;

    logic start;
    logic counting;
    logic tick;
    logic win_end;
    logic accept;

    assign start    = (state == IDLE) && launch;
    assign counting = (state == BLANK) || (state == LISTEN);
    assign tick     = (cyc_cnt == CYC_W'(TICK_DIV - 1));
    assign win_end  = (us_cnt == TOF_W'(WINDOW_US));
    assign accept   = (state == REPORT) && res_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_qual
        echo_qualifier #(
            .DEBOUNCE(DEBOUNCE)
        ) u_qual (
            .clk_50M(clk_50M),
            .rst    (rst),
            .echo_in(echo_in[i]),
            .qual   (qual[i])
        );
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = BLANK;
            BLANK:   if (us_cnt == TOF_W'(BLANK_US)) state_nxt = LISTEN;
            LISTEN:  if (win_end || (&hit)) state_nxt = REPORT;
            REPORT:  if (res_ready && rpt_idx == IDX_W'(NUM_CH - 1))
                         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst || start) begin
            cyc_cnt <= '0;
            us_cnt  <= '0;
        end else if (counting) begin
            cyc_cnt <= tick ? '0 : cyc_cnt + 1'b1;
            if (tick) us_cnt <= us_cnt + 1'b1;
        end
    end

    // First qualified echo per channel wins; the window-end cycle is excluded.
    always_ff @(posedge clk_50M) begin
        if (rst || start) begin
            hit <= '0;
            for (int i = 0; i < NUM_CH; i++) tof[i] <= '0;
        end else if (state == LISTEN && !win_end) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (qual[i] && !hit[i]) begin
                    hit[i] <= 1'b1;
                    tof[i] <= us_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst || start) begin
            rpt_idx <= '0;
        end else if (accept) begin
            rpt_idx <= rpt_idx + 1'b1;
        end
    end

    always_comb begin
        res_valid = 1'b0;
        res_ch    = '0;
        res_hit   = 1'b0;
        res_tof   = '0;
        busy      = (state != IDLE);
        missed    = launch && (state != IDLE);
        if (state == REPORT) begin
            res_valid = 1'b1;
            res_ch    = rpt_idx;
            res_hit   = hit[rpt_idx];
            res_tof   = tof[rpt_idx];
        end
    end

endmodule

// File: tb/tb_ultrasound_echo_receiver.sv
// Bench for ultrasound_echo_receiver: table vectors, corner sequences
// and random echo patterns checked against a latency-rule model.
module tb_ultrasound_echo_receiver;

    localparam int TD     = 16;
    localparam int BLANK  = 8;
    localparam int WINDOW = 240;
    localparam int DEB    = 8;
    localparam int TW     = 14;
    localparam int BIG    = 1 << 30;
    localparam int LIMIT  = WINDOW * TD + 32;
`ifdef ECHO_GLITCH_FILTER_EN
    localparam int LAT        = 2 + DEB;
    localparam int PW         = DEB;
    localparam int GLITCH_TOF = 75;
`else
    localparam int LAT        = 2;
    localparam int PW         = 1;
    localparam int GLITCH_TOF = 50;
`endif

    logic          clk_50M = 1'b0;
    logic          rst = 1'b1;
    logic          launch = 1'b0;
    logic [3:0]    echo_in = '0;
    logic          res_ready = 1'b0;
    logic          res_valid;
    logic [1:0]    res_ch;
    logic          res_hit;
    logic [TW-1:0] res_tof;
    logic          busy;
    logic          missed;

    ultrasound_echo_receiver #(
        .TICK_DIV (TD),
        .BLANK_US (BLANK),
        .WINDOW_US(WINDOW),
        .DEBOUNCE (DEB),
        .TOF_W    (TW)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .launch   (launch),
        .echo_in  (echo_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_ch   (res_ch),
        .res_hit  (res_hit),
        .res_tof  (res_tof),
        .busy     (busy),
        .missed   (missed)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct packed {
        int ch;
        int s;
        int e;
    } pulse_t;

    typedef struct packed {
        logic [3:0][15:0] s0, e0, s1, e1;
        logic [3:0]       hit;
        logic [3:0][13:0] tof;
    } vec_t;

    pulse_t pq[$];
    vec_t   tbl[6];
    int     tests = 0;
    int     fails = 0;
    string  cur = "reset";

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s/%s: got %0d, want %0d", cur, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    function automatic logic wave_bit(int ch, int j);
        foreach (pq[k])
            if (pq[k].ch == ch && j >= pq[k].s && j < pq[k].e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] wave_vec(int j);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch] = wave_bit(ch, j);
        return v;
    endfunction

    // Qualified at cycle c: echo seen LAT cycles earlier, held long enough.
    function automatic logic model_qual(int ch, int c);
`ifdef ECHO_GLITCH_FILTER_EN
        for (int k = c - 2 - DEB; k <= c - 3; k++)
            if (!wave_bit(ch, k)) return 1'b0;
        return 1'b1;
`else
        return wave_bit(ch, c - 2);
`endif
    endfunction

    task automatic model(output logic [3:0] h, output logic [3:0][13:0] t);
        h = '0;
        t = '0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int c = BLANK * TD + 1; c < WINDOW * TD; c++) begin
                if (model_qual(ch, c)) begin
                    h[ch] = 1'b1;
                    t[ch] = 14'(c / TD);
                    break;
                end
            end
        end
    endtask

    function automatic vec_t empty_vec();
        vec_t v;
        v.s0  = '1;
        v.e0  = '1;
        v.s1  = '1;
        v.e1  = '1;
        v.hit = '0;
        v.tof = '0;
        return v;
    endfunction

    task automatic add_pulse(input int ch, input logic [15:0] s,
                             input logic [15:0] e);
        pulse_t p;
        if (s == 16'hFFFF) return;
        p.ch = ch;
        p.s  = int'(s);
        p.e  = (e == 16'hFFFF) ? BIG : int'(e);
        pq.push_back(p);
    endtask

    task automatic load_vec(input vec_t v);
        pq.delete();
        for (int ch = 0; ch < 4; ch++) begin
            add_pulse(ch, v.s0[ch], v.e0[ch]);
            add_pulse(ch, v.s1[ch], v.e1[ch]);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ch"}, res_ch, 0);
        chk({tag, "_hit"}, res_hit, 0);
        chk({tag, "_tof"}, res_tof, 0);
        chk({tag, "_missed"}, missed, 0);
    endtask

    task automatic run_launch(input logic [3:0] eh, input logic [3:0][13:0] et,
                              input int stall, input bit try_l);
        int j;
        launch  = 1'b1;
        echo_in = '0;
        step();
        launch = 1'b0;
        chk("busy_on_launch", busy, 1);
        j = 0;
        echo_in = wave_vec(0);
        while (!res_valid && j < LIMIT) begin
            step();
            j++;
            echo_in = wave_vec(j);
        end
        echo_in = '0;
        if (!res_valid) begin
            chk("report_timeout", 0, 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                for (int s = 0; s < stall; s++) begin
                    res_ready = 1'b0;
                    if (try_l && s == 5) begin
                        launch = 1'b1;
                        #1;
                        chk("missed_pulse", missed, 1);
                    end
                    chk("stall_valid", res_valid, 1);
                    chk("stall_ch", res_ch, k);
                    chk("stall_hit", res_hit, eh[k]);
                    chk("stall_tof", res_tof, et[k]);
                    step();
                    if (launch) begin
                        launch = 1'b0;
                        #1;
                        chk("missed_clear", missed, 0);
                        chk("missed_busy", busy, 1);
                    end
                end
            end
            res_ready = 1'b1;
            chk("valid", res_valid, 1);
            chk("ch", res_ch, k);
            chk($sformatf("hit%0d", k), res_hit, eh[k]);
            chk($sformatf("tof%0d", k), res_tof, et[k]);
            step();
        end
        res_ready = 1'b0;
        chk("busy_fall", busy, 0);
        chk("valid_fall", res_valid, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          v;
        pulse_t        p;
        logic [3:0]       h;
        logic [3:0][13:0] t;

        tbl[0] = empty_vec();
        v = empty_vec();
        v.s0[2] = 16'(30 * TD + 5);
        v.hit = 4'b0100;
        v.tof[2] = 14'd30;
        tbl[1] = v;
        v = empty_vec();
        v.s0[1] = 16'(2 * TD);
        v.e0[1] = 16'(6 * TD);
        tbl[2] = v;
        v = empty_vec();
        for (int ch = 0; ch < 4; ch++) begin
            v.s0[ch] = 16'(10 * TD);
            v.tof[ch] = 14'd10;
        end
        v.hit = 4'b1111;
        tbl[3] = v;
        v = empty_vec();
        v.s0[0] = 16'(50 * TD);
        v.e0[0] = 16'(50 * TD + 5);
        v.s1[0] = 16'(75 * TD);
        v.hit = 4'b0001;
        v.tof[0] = 14'(GLITCH_TOF);
        tbl[4] = v;
        v = empty_vec();
        v.s0[1] = 16'(BLANK * TD - LAT);
        v.e0[1] = 16'(BLANK * TD - LAT + PW);
        v.s0[2] = 16'(BLANK * TD + 1 - LAT);
        v.e0[2] = 16'(BLANK * TD + 1 - LAT + PW);
        v.s0[0] = 16'(WINDOW * TD - 1 - LAT);
        v.s0[3] = 16'(WINDOW * TD - LAT);
        v.hit = 4'b0101;
        v.tof[0] = 14'(WINDOW - 1);
        v.tof[2] = 14'(BLANK);
        tbl[5] = v;

        rst = 1'b1;
        repeat (3) step();
        chk_idle("rst");
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            cur = $sformatf("vec%0d", i);
            load_vec(tbl[i]);
            run_launch(tbl[i].hit, tbl[i].tof, (i == 1) ? 20 : 0, i == 1);
        end

        cur = "mid_reset";
        pq.delete();
        p.ch = 0;
        p.s = 20 * TD;
        p.e = BIG;
        pq.push_back(p);
        launch = 1'b1;
        step();
        launch = 1'b0;
        for (int j = 0; j < 37 * TD; j++) begin
            echo_in = wave_vec(j);
            step();
        end
        chk("busy_mid", busy, 1);
        rst = 1'b1;
        echo_in = '0;
        step();
        rst = 1'b0;
        chk_idle("after_rst");
        cur = "fresh";
        load_vec(tbl[1]);
        run_launch(tbl[1].hit, tbl[1].tof, 0, 0);

        for (int r = 0; r < 4; r++) begin
            cur = $sformatf("rand%0d", r);
            pq.delete();
            for (int ch = 0; ch < 4; ch++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    p.ch = ch;
                    p.s = $urandom_range(0, WINDOW * TD + 50);
                    p.e = ($urandom_range(0, 3) == 0) ? BIG
                        : p.s + $urandom_range(1, 30);
                    pq.push_back(p);
                end
            end
            model(h, t);
            run_launch(h, t, $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ultrasound_echo_receiver.md
# ultrasound_echo_receiver

Receive side of the 4-channel 90 kHz ultrasound system. The launcher fires a burst on VIN_1..VIN_4 every 10 ms; this block starts on that launch, ignores transducer ringing for a blanking interval, then timestamps the first qualified echo on each of the four comparator inputs in 1 µs units. After the listen window closes, it reports one result per channel, ch0..ch3, over a valid/ready stream.

## Interface
Parameters:
- TICK_DIV, 50 — clk_50M cycles per 1 µs tick
- BLANK_US, 300 — µs after launch during which echoes are ignored
- WINDOW_US, 9500 — µs after launch at which listening ends; must be < 10000
- DEBOUNCE, 8 — consecutive high samples required to qualify an echo (filter build only)
- TOF_W, 14 — time-of-flight width; 2^TOF_W > WINDOW_US

Ports:
- clk_50M  in  1  system clock, 50 MHz; the only clock
- rst  in  1  reset, synchronous, active-high
- launch  in  1  one-cycle pulse, coincident with the burst start
- echo_in  in  4  asynchronous comparator outputs; bit i is channel i
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_ch  out  2  channel index of the result
- res_hit  out  1  1 = echo found; 0 = timeout
- res_tof  out  TOF_W  µs from launch to echo; 0 when res_hit=0
- busy  out  1  high in any state other than IDLE
- missed  out  1  one-cycle pulse when a launch arrives while busy

## Operation
- States: IDLE, BLANK, LISTEN, REPORT.
- IDLE, launch=1:
  - clear all hit flags, TOF registers, cyc_cnt and us_cnt
  - go to BLANK
- Tick counting:
  - cyc_cnt counts 0..TICK_DIV-1 and wraps.
  - us_cnt increments on the cycle cyc_cnt wraps.
  - Both counters run in BLANK and LISTEN only.
- BLANK → LISTEN when us_cnt == BLANK_US. Qualifier outputs are discarded in BLANK.
- LISTEN:
  - For channel i with hit[i]=0, a qualified echo sets hit[i]=1 and tof[i]=us_cnt in that cycle.
  - After hit[i]=1, further echoes on channel i are ignored (first echo only).
- LISTEN → REPORT when us_cnt == WINDOW_US, or when all four hit flags are set, whichever comes first. On entry, the report index is 0.
- REPORT:
  - res_valid=1; res_ch/res_hit/res_tof show the entry at the report index.
  - On res_valid && res_ready, the index increments.
  - When index 3 is accepted, go to IDLE.
- launch outside IDLE is ignored and pulses missed for 1 cycle.
- Qualifier, per channel: 2-flop synchronizer, then the filter described under Configuration.

## Timing
- Reset: every output is 0, state is IDLE, and all counters, hit flags and TOF registers are cleared. A reset mid-LISTEN or mid-REPORT aborts and drops the results.
- launch in cycle N: busy=1 and cyc_cnt=0, us_cnt=0 in cycle N+1.
- Echo detection latency from the echo_in edge:
  - filter build: 2 + DEBOUNCE cycles
  - unfiltered build: 2 cycles
- The TOF is the us_cnt value in the qualifying cycle.
- res_valid rises in the first REPORT cycle and stays high until the handshake. res_ch/res_hit/res_tof are stable while res_valid && !res_ready.
- Back-to-back acceptance gives one result per cycle, so the minimum REPORT duration is 4 cycles.
- An echo qualifying in the same cycle as the window end (us_cnt == WINDOW_US) is not recorded.
- busy falls the cycle after ch3 is accepted. A launch in that next cycle is accepted normally.

## Configuration
- ECHO_GLITCH_FILTER_EN defined:
  - A per-channel counter counts consecutive synchronized high samples and resets on any low sample.
  - The channel qualifies when the counter reaches DEBOUNCE.
- ECHO_GLITCH_FILTER_EN undefined:
  - Any synchronized high sample in LISTEN qualifies.
  - The DEBOUNCE parameter is unused.

## Structure
- Shared package ultrasound_pkg holds:
  - the state enum (IDLE/BLANK/LISTEN/REPORT)
  - NUM_CH = 4
  - the default TOF_W
- Sub-module echo_qualifier (synchronizer plus filter, honours the macro), instantiated once per channel.
- The top level holds the tick counters, the FSM, the hit/TOF arrays and the report mux.

## Test plan
- No echo: launch with echo_in=0 → after 9500 µs, four results ch0..3, each with hit=0 and tof=0; busy then falls.
- Echo on ch2: rises at us_cnt=1200 with cyc_cnt=5 and is held high → ch2 hit=1, tof=1200; ch0, ch1 and ch3 hit=0.
- Echo during blanking: ch1 high from 100 to 250 µs, then low → ch1 hit=0. All four channels high at 400 µs → early REPORT with tof=400 on every channel.
- Glitch on ch0: 5-cycle pulse at 2000 µs, then a solid echo at 3000 µs → filter build reports tof=3000; unfiltered build reports tof=2000.
- Backpressure: res_ready low for 20 cycles in REPORT → outputs unchanged. A launch during REPORT → missed pulse for 1 cycle, with no state change.
- Reset mid-LISTEN: rst asserted at 1500 µs → the next cycle shows all outputs 0 and state IDLE. A following launch gives correct fresh results.
